bus_timer: RTL and testbench

- Programmable interval timer that sits behind the CPU/IO bridge as a memory-mapped device and drives one HWInt line (HWInt[2]).
- The CPU configures and sequences it through three word registers: CTRL, PRESET and COUNT.
- It supports a one-shot mode with a sticky interrupt and an auto-reload mode with a periodic 1-cycle interrupt pulse.

---
 rtl/bus_timer_if.sv | 28 ++
 rtl/bus_timer.sv | 139 +++++++++++++
 tb/tb_bus_timer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_if
// Description : Bridge-side word bus of the interval timer: address, write
//               strobe, byte enables, write/read data and interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_timer_if;
  logic [1:0]  addr;  // word address: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
  logic        we;    // one-cycle write strobe
  logic [3:0]  be;    // byte enables, lane i = wd[8i+7:8i]
  logic [31:0] wd;    // write data
  logic [31:0] rd;    // read data, combinational from addr
  logic        irq;   // interrupt request towards HWInt

  // Bridge side drives the bus and observes data/interrupt
  modport master (
    output addr, we, be, wd,
    input  rd, irq
  );

  // Timer side observes the bus and returns data/interrupt
  modport slave (
    input  addr, we, be, wd,
    output rd, irq
  );
endinterface
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped programmable interval timer with one-shot
//               (sticky interrupt) and auto-reload (1-cycle pulse) modes.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer #(
  parameter int CNT_WIDTH = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  bus_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_one  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_zero = '0;

  state_t               state_q, state_d;
  logic [3:0]           ctrl_q, ctrl_d;        // {IM, MODE[1:0], EN}
  logic [CNT_WIDTH-1:0] preset_q, preset_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 irq_sticky_q, irq_sticky_d;

  logic                 ctrl_wr;
  logic                 preset_wr;
  logic                 auto_reload;
  logic [31:0]          preset_merge;

  // Register file writes and timer sequencing, computed as next-state values
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    preset_d     = preset_q;
    count_d      = count_q;
    irq_sticky_d = irq_sticky_q;

    ctrl_wr     = bus.we && (bus.addr == 2'd0);
    preset_wr   = bus.we && (bus.addr == 2'd1);
    // Only MODE=1 reloads; the two unused encodings fall back to one-shot.
    auto_reload = (ctrl_q[2:1] == 2'b01);

    // Byte-lane merge on the zero-extended value; lanes beyond the counter
    // width fall off when truncated back.
    preset_merge = 32'(preset_q);
    for (int i = 0; i < 4; i++) begin
      if (bus.be[i]) begin
        preset_merge[8*i +: 8] = bus.wd[8*i +: 8];
      end
    end
    if (preset_wr) begin
      preset_d = preset_merge[CNT_WIDTH-1:0];
    end

    // Any CTRL access acknowledges the interrupt, even with no lanes enabled.
    if (ctrl_wr) begin
      irq_sticky_d = 1'b0;
      if (bus.be[0]) begin
        ctrl_d = bus.wd[3:0];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q > c_one) begin
          count_d = count_q - c_one;
        end else begin
          count_d = c_zero;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          state_d = ST_LOAD;
        end else begin
          state_d      = ST_IDLE;
          // Expiry wins over a coincident acknowledge so no event is lost,
          // while a coincident CPU write of CTRL keeps the CPU's EN value.
          irq_sticky_d = 1'b1;
          if (!(ctrl_wr && bus.be[0])) begin
            ctrl_d[0] = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= 4'h0;
      preset_q     <= c_zero;
      count_q      <= c_zero;
      irq_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      preset_q     <= preset_d;
      count_q      <= count_d;
      irq_sticky_q <= irq_sticky_d;
    end
  end

  // Read mux, combinational from the word address
  always_comb begin
    bus.rd = 32'h0;
    unique case (bus.addr)
      2'd0:    bus.rd = {28'h0, ctrl_q};
      2'd1:    bus.rd = 32'(preset_q);
      2'd2:    bus.rd = 32'(count_q);
      default: bus.rd = 32'h0;
    endcase
  end

  // Interrupt is a pure function of registers, so it cannot glitch mid-cycle
  assign bus.irq = ctrl_q[3] & (irq_sticky_q | (state_q == ST_INT));

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer
// Description : Self-checking bench for bus_timer. Expected register values
//               and interrupt timing come from closed-form rules of the timer
//               (load latency, countdown, reload period), not from a replica
//               of the state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_timer_if bif ();

  bus_timer #(.CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_count;       // COUNT value the model expects while idle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus write; the edge it consumes is the write edge
  task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    bif.we   = 1'b1;
    bif.addr = a;
    bif.be   = b;
    bif.wd   = d;
    @(posedge clk);
    #1;
    bif.we = 1'b0;
    bif.be = 4'h0;
    bif.wd = 32'h0;
  endtask

  task automatic rdv(input logic [1:0] a, output logic [31:0] v);
    bif.addr = a;
    #1;
    v = bif.rd;
  endtask

  // Cycles after the enable write until the interrupt cycle: two cycles to
  // reach the loaded count, then one decrement per cycle (at least one).
  function automatic int os_t(input int p);
    return 2 + ((p < 1) ? 1 : p);
  endfunction

  function automatic logic [31:0] os_count(input int k, input int p, input logic [31:0] c0);
    int v;
    if (k < 2) return c0;
    v = p - (k - 2);
    return (v < 0) ? 32'h0 : 32'(v);
  endfunction

  // Auto-reload: period p+2 made of p counting cycles, the interrupt cycle
  // and the reload cycle (both of which show COUNT=0).
  function automatic logic [31:0] ar_count(input int k, input int p, input logic [31:0] c0);
    int j;
    if (k < 2) return c0;
    j = (k - 2) % (p + 2);
    return (j < p) ? 32'(p - j) : 32'h0;
  endfunction

  function automatic logic ar_irq(input int k, input int p);
    return (k >= 2 + p) && (((k - 2 - p) % (p + 2)) == 0);
  endfunction

  // One-shot run. hi = {IM, MODE}. Optional PRESET write at edge w_at.
  // Leaves the bench positioned at k = os_t(p) + extra.
  task automatic run_oneshot(input string tag, input int p, input logic [2:0] hi,
                             input int w_at, input logic [31:0] w_val, input int extra);
    logic [31:0] v;
    int          t;
    int          last;
    t    = os_t(p);
    last = t + extra;
    wr(2'd1, 4'hF, 32'(p));
    wr(2'd0, 4'h1, {28'h0, hi, 1'b1});
    for (int k = 0; k <= last; k++) begin
      rdv(2'd2, v);
      chk({tag, " count"}, v, os_count(k, p, m_count));
      chk({tag, " irq"}, 32'(bif.irq), 32'(hi[2] && (k >= t)));
      if (k == t + 1) begin
        rdv(2'd0, v);
        chk({tag, " ctrl EN cleared"}, v, {28'h0, hi, 1'b0});
      end
      if (k < last) begin
        if (k + 1 == w_at) wr(2'd1, 4'hF, w_val);
        else               tick();
      end
    end
    m_count = 32'h0;
  endtask

  // Auto-reload run for 'periods' full periods plus 'off' cycles, then stop.
  task automatic run_ar(input string tag, input int p, input int periods, input int off);
    logic [31:0] v;
    logic [31:0] held;
    int          kend;
    int          j;
    kend = 2 + p + periods * (p + 2) + off;
    wr(2'd1, 4'hF, 32'(p));
    wr(2'd0, 4'h1, 32'hB);
    for (int k = 0; k <= kend; k++) begin
      rdv(2'd2, v);
      chk({tag, " count"}, v, ar_count(k, p, m_count));
      chk({tag, " irq"}, 32'(bif.irq), 32'(ar_irq(k, p)));
      if (k < kend) tick();
    end
    // Stop write lands on edge kend+1. If the counter is mid-count it halts
    // right there; if it is in the interrupt or reload cycle, the reload
    // still completes and it halts holding PRESET.
    wr(2'd0, 4'h1, 32'hA);
    j    = (kend + 1 - 2) % (p + 2);
    held = (j < p) ? 32'(p - j) : 32'(p);
    tick(); tick(); tick();
    for (int i = 0; i < 8; i++) begin
      rdv(2'd2, v);
      chk({tag, " stopped count"}, v, held);
      chk({tag, " stopped irq"}, 32'(bif.irq), 32'h0);
      tick();
    end
    rdv(2'd0, v);
    chk({tag, " ctrl after stop"}, v, 32'hA);
    m_count = held;
  endtask

  initial begin : main
    logic [31:0] v;
    int          p;
    logic [1:0]  mode;
    logic        im;

    rst      = 1'b1;
    bif.we   = 1'b0;
    bif.addr = 2'd0;
    bif.be   = 4'h0;
    bif.wd   = 32'h0;
    tick();
    tick();
    rst     = 1'b0;
    m_count = 32'h0;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rdv(2'(a), v);
      chk("reset rd", v, 32'h0);
    end
    chk("reset irq", 32'(bif.irq), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle irq", 32'(bif.irq), 32'h0);
    end

    // One-shot PRESET=5, IM=1; interrupt held 50 cycles, then acknowledged
    run_oneshot("os5", 5, 3'b100, -1, 32'h0, 50);
    wr(2'd0, 4'h1, 32'h8);
    chk("os5 ack irq", 32'(bif.irq), 32'h0);

    // Auto-reload PRESET=3, period 5, four periods
    run_ar("ar3", 3, 4, 2);

    // Masked one-shot: expiry invisible, byte write of CTRL clears sticky
    run_oneshot("mask", 2, 3'b000, -1, 32'h0, 5);
    wr(2'd0, 4'h1, 32'h8);
    chk("mask irq after clear", 32'(bif.irq), 32'h0);
    rdv(2'd0, v);
    chk("mask ctrl", v, 32'h8);
    tick();
    chk("mask irq later", 32'(bif.irq), 32'h0);

    // Byte-enable merge on PRESET
    wr(2'd1, 4'hF, 32'hAABBCCDD);
    wr(2'd1, 4'h5, 32'h11223344);
    rdv(2'd1, v);
    chk("preset byte merge", v, 32'hAA22CC44);

    // CTRL write with no lanes: CTRL unchanged, pending irq cleared
    run_oneshot("be0", 1, 3'b100, -1, 32'h0, 3);
    wr(2'd0, 4'h0, 32'hF);
    rdv(2'd0, v);
    chk("be0 ctrl kept", v, 32'h8);
    chk("be0 irq cleared", 32'(bif.irq), 32'h0);

    // CPU write of CTRL on the expiry edge: CPU bits win, sticky still set
    run_oneshot("col", 2, 3'b100, -1, 32'h0, 0);
    wr(2'd0, 4'h1, 32'h8);
    rdv(2'd0, v);
    chk("col ctrl", v, 32'h8);
    chk("col irq sticky", 32'(bif.irq), 32'h1);
    wr(2'd0, 4'h1, 32'h8);
    chk("col ack irq", 32'(bif.irq), 32'h0);

    // EN cleared during the load cycle: load completes, then idles
    wr(2'd1, 4'hF, 32'd7);
    wr(2'd0, 4'h1, 32'h9);
    tick();
    wr(2'd0, 4'h1, 32'h8);
    for (int i = 0; i < 5; i++) begin
      rdv(2'd2, v);
      chk("load abort count", v, 32'd7);
      chk("load abort irq", 32'(bif.irq), 32'h0);
      tick();
    end
    m_count = 32'd7;

    // PRESET rewritten mid-count: running count unaffected
    run_oneshot("pw", 6, 3'b100, 4, 32'h2, 2);
    rdv(2'd1, v);
    chk("pw preset", v, 32'h2);
    wr(2'd0, 4'h1, 32'h8);

    // Randomized one-shot runs (modes 0/2/3, random mask)
    for (int i = 0; i < 4; i++) begin
      p = $urandom_range(0, 12);
      case ($urandom_range(0, 2))
        0:       mode = 2'd0;
        1:       mode = 2'd2;
        default: mode = 2'd3;
      endcase
      im = 1'($urandom_range(0, 1));
      run_oneshot("rnd_os", p, {im, mode}, -1, 32'h0, 3);
      wr(2'd0, 4'h0, 32'h0);
      rdv(2'd0, v);
      chk("rnd_os ctrl", v, {28'h0, im, mode, 1'b0});
      chk("rnd_os irq cleared", 32'(bif.irq), 32'h0);
    end

    // Randomized auto-reload runs with a random stop point
    for (int i = 0; i < 2; i++) begin
      p = $urandom_range(1, 8);
      run_ar("rnd_ar", p, 2 + i, $urandom_range(0, p + 1));
    end

    // PRESET=0 one-shot: behaves as a count of one
    run_oneshot("p0", 0, 3'b100, -1, 32'h0, 2);
    wr(2'd0, 4'h1, 32'h8);

    // Reset while COUNT=3 aborts without an interrupt
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'h1, 32'h9);
    for (int k = 0; k < 9; k++) tick();
    rdv(2'd2, v);
    chk("pre-reset count", v, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdv(2'd2, v);
    chk("mid reset count", v, 32'h0);
    rdv(2'd0, v);
    chk("mid reset ctrl", v, 32'h0);
    rdv(2'd1, v);
    chk("mid reset preset", v, 32'h0);
    chk("mid reset irq", 32'(bif.irq), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post reset irq", 32'(bif.irq), 32'h0);
    end
    rdv(2'd2, v);
    chk("post reset count", v, 32'h0);

    // Writes to COUNT and the reserved word are ignored
    wr(2'd2, 4'hF, 32'h0000FFFF);
    rdv(2'd2, v);
    chk("count write ignored", v, 32'h0);
    wr(2'd3, 4'hF, 32'hFFFFFFFF);
    rdv(2'd3, v);
    chk("reserved reads 0", v, 32'h0);
    rdv(2'd0, v);
    chk("ctrl untouched", v, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
